// File: rtl/leak_pkg.sv
// rtl/leak_pkg.sv - shared mode encodings and LFSR constants for the leak pattern generator
package leak_pkg;

  localparam int LFSR_W = 8;

  // Fibonacci taps 8,6,5,4 expressed as state bit positions 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    MODE_CONST   = 2'b00,
    MODE_DIRECT  = 2'b01,
    MODE_MASKED  = 2'b10,
    MODE_DELAYED = 2'b11
  } mode_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/leak_pattern_gen_if.sv
// rtl/leak_pattern_gen_if.sv - control and pattern signals of the leak pattern generator
interface leak_pattern_gen_if
  import leak_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ASSET_W = 2,
  parameter int CNT_W   = 3
);

  logic               enable;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   leak_slot;
  logic [ASSET_W-1:0] asset;
  logic [DATA_W-1:0]  data_out;
  logic               frame_start;
  logic [LFSR_W-1:0]  lfsr_state;

  modport master (
    output enable, mode, leak_slot, asset,
    input  data_out, frame_start, lfsr_state
  );

  modport slave (
    input  enable, mode, leak_slot, asset,
    output data_out, frame_start, lfsr_state
  );

endinterface

// File: rtl/leak_pattern_gen_lfsr8.sv
// rtl/leak_pattern_gen_lfsr8.sv - enable-gated 8-bit Fibonacci LFSR
module lfsr8
  import leak_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED   = 8'hA5,
  parameter int                MASK_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [LFSR_W-1:0] state,
  output logic [MASK_W-1:0] mask_next
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (enable) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state     = state_q;
  // low bits of the value the register is about to take, used by the masked leak
  assign mask_next = state_d[MASK_W-1:0];

endmodule

// File: rtl/leak_pattern_gen.sv
// rtl/leak_pattern_gen.sv - frame-based test pattern generator with one programmable leak slot
module leak_pattern_gen
  import leak_pkg::*;
#(
  parameter int                DATA_W    = 4,
  parameter int                ASSET_W   = 2,
  parameter int                CNT_W     = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input logic               clk,
  input logic               reset,
  leak_pattern_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] SLOT_MAX = '1;
  localparam logic [CNT_W-1:0] SLOT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_n;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   slot_q, slot_d;
  logic [ASSET_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               fs_q, fs_d;
  logic [ASSET_W-1:0] mask_n;
  logic               delay_hit;

  function automatic logic [DATA_W-1:0] with_low(input logic [ASSET_W-1:0] low);
    logic [DATA_W-1:0] r;
    r              = '1;
    r[ASSET_W-1:0] = low;
    return r;
  endfunction

  lfsr8 #(
    .SEED   (LFSR_SEED),
    .MASK_W (ASSET_W)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .enable    (bus.enable),
    .state     (bus.lfsr_state),
    .mask_next (mask_n)
  );

  assign cnt_n = cnt_q + SLOT_ONE;

  // a leak slot in the last position spills its held value into slot 1 of the next frame
  assign delay_hit = (slot_q != SLOT_MAX) ? (cnt_n == slot_q + SLOT_ONE)
                                          : (cnt_n == SLOT_ONE);

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    slot_d = slot_q;
    hold_d = hold_q;
    data_d = data_q;
    fs_d   = 1'b0;
    if (bus.enable) begin
      cnt_d = cnt_n;
      fs_d  = (cnt_n == '0);
      if (cnt_n == '0) begin
        mode_d = mode_e'(bus.mode);
        slot_d = bus.leak_slot;
        data_d = '0;
      end else begin
        data_d = '1;
        if (slot_q != '0) begin
          case (mode_q)
            MODE_DIRECT: begin
              if (cnt_n == slot_q) data_d = with_low(bus.asset);
            end
            MODE_MASKED: begin
              if (cnt_n == slot_q) data_d = with_low(bus.asset ^ mask_n);
            end
            MODE_DELAYED: begin
              if (cnt_n == slot_q) hold_d = bus.asset;
              if (delay_hit) data_d = with_low(hold_q);
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      mode_q <= MODE_CONST;
      slot_q <= '0;
      hold_q <= '0;
      data_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      slot_q <= slot_d;
      hold_q <= hold_d;
      data_q <= data_d;
      fs_q   <= fs_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.frame_start = fs_q & bus.enable;

endmodule

// File: doc/leak_pattern_gen.md
Name: leak_pattern_gen

Overview:
- Parametrised frame-based test-pattern generator for QIF characterisation.
- A free-running slot counter defines frames of 2^CNT_W slots. Each slot drives a constant pattern on `data_out`, except one programmable leak slot.
- In the leak slot, `asset` bits appear on the output directly, LFSR-masked, or one slot late, depending on mode.
- Used as a known-leakage device under test for the toolbox's flow-measurement flow.

Parameters:
- DATA_W, 4, output width; must be >= ASSET_W.
- ASSET_W, 2, asset input width; range 1..8.
- CNT_W, 3, slot counter width; frame length is 2^CNT_W slots.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- enable  in  1  advance counter/LFSR and update outputs when high.
- mode  in  2  leak mode: 00 CONST, 01 DIRECT, 10 MASKED, 11 DELAYED.
- leak_slot  in  CNT_W  slot index that carries asset information.
- asset  in  ASSET_W  secret input.
- data_out  out  DATA_W  registered pattern output.
- frame_start  out  1  high for one enabled cycle when the new slot is 0.
- lfsr_state  out  8  current LFSR value, for bench mask reconstruction.

Behaviour:
- Reset values:
  - cnt=0, data_out=0, frame_start=0, lfsr=LFSR_SEED.
  - mode_q=00, slot_q=0, held asset register hold_q=0.
  - Reset overrides enable and is honoured mid-frame.
- Counter and LFSR:
  - enable=0 freezes all state, outputs hold.
  - enable=1: cnt_n = cnt+1, wrapping modulo 2^CNT_W, so 2^CNT_W-1 -> 0.
  - LFSR is 8-bit Fibonacci, taps 8,6,5,4: new bit = l[7]^l[5]^l[4]^l[3], shifted in at bit 0. It advances on every enabled cycle.
- Latency:
  - data_out is computed from cnt_n (the post-increment slot) and registered in the same edge.
  - The output therefore reflects the slot entered at that edge, one clock after the enabled cycle.
- Configuration capture:
  - mode_q and slot_q load from mode/leak_slot only on an enabled edge where cnt_n==0.
  - Changes mid-frame take effect at the next frame.
  - The first frame after reset uses CONST until the first wrap.
- Output function, for slot s=cnt_n (ones = all DATA_W bits 1):
  - s==0: data_out=0 in all modes; frame_start=1.
  - CONST: data_out=ones for every s!=0.
  - DIRECT: s==slot_q gives data_out = {ones[DATA_W-1:ASSET_W], asset}; any other s!=0 gives ones.
  - MASKED: s==slot_q gives low bits = asset ^ lfsr_n[ASSET_W-1:0], where lfsr_n is the post-advance value also visible on lfsr_state; upper bits ones. Any other s!=0 gives ones.
  - DELAYED:
    - On entering s==slot_q, hold_q <= asset and data_out = ones.
    - On entering s==slot_q+1, data_out low bits = hold_q.
    - If slot_q+1 wraps to 0, the held value is output in slot 1 of the next frame instead. The slot-0 zero output still takes precedence.
- Boundary rules:
  - slot_q==0: no leak in any mode, because the slot-0 zero output wins.
  - frame_start is 0 on any cycle where enable=0.
  - DATA_W==ASSET_W: there are no upper ones bits.

Decomposition:
- Package leak_pkg holds:
  - mode encodings MODE_CONST/DIRECT/MASKED/DELAYED;
  - LFSR tap constant;
  - LFSR width constant 8.
- One sub-module, lfsr8: enable-gated, seed parameter, 8-bit state output.
- Counter, config capture and output mux stay in the top module.

Test Plan:
- Reset, then enable held high with mode=00 for two frames, defaults:
  - data_out sequence per frame is 0,F,F,F,F,F,F,F.
  - frame_start is high on the zeros.
- Mode=01, leak_slot=3, asset=2'b10, enable high through the first wrap:
  - second frame is 0,F,F,E,F,F,F,F.
  - asset changes in other slots have no effect.
- Mode=10, leak_slot=5, asset=2'b11:
  - in slot 5, data_out[1:0] == 2'b11 ^ lfsr_state[1:0] and data_out[3:2]=2'b11.
  - the bench model of the LFSR from seed A5 matches lfsr_state every enabled cycle.
- Mode=11, leak_slot=7, asset=2'b01 in slot 7, then asset=2'b10:
  - slot 7 output is F.
  - next frame reads 0, then D in slot 1.
- enable toggling 1,0,0,1 mid-frame:
  - counter, LFSR and data_out hold during the low cycles.
  - frame_start is never high while enable=0.
  - the sequence resumes without a skipped slot.
- Reset asserted in slot 4 of a DIRECT frame, and mode changed mid-frame:
  - next cycle data_out=0, lfsr_state=A5, cnt=0.
  - the following frame runs CONST.
  - a mid-frame mode change has no effect until the next slot-0 edge.
